// File: rtl/mem_access_controller_if.sv
// Signal bundle between the MEM stage / data bus and mem_access_controller.
// slave is the controller's view; master is the pipeline-plus-bus environment's view.
interface mem_access_controller_if;
    logic        MEM_MemRead;
    logic        MEM_MemWrite;
    logic [1:0]  MEM_Size;
    logic        MEM_SignExtend;
    logic [31:0] MEM_Address;
    logic [31:0] MEM_WriteData;
    logic        MEM_Stall_Controller;
    logic [31:0] MEM_ReadData;
    logic        MEM_BusError;
    logic [31:0] Bus_Address;
    logic [31:0] Bus_WriteData;
    logic [3:0]  Bus_ByteEnable;
    logic        Bus_Read;
    logic        Bus_Write;
    logic        Bus_Ready;
    logic [31:0] Bus_ReadData;

    modport slave (
        input  MEM_MemRead, MEM_MemWrite, MEM_Size, MEM_SignExtend, MEM_Address, MEM_WriteData,
        input  Bus_Ready, Bus_ReadData,
        output MEM_Stall_Controller, MEM_ReadData, MEM_BusError,
        output Bus_Address, Bus_WriteData, Bus_ByteEnable, Bus_Read, Bus_Write
    );

    modport master (
        output MEM_MemRead, MEM_MemWrite, MEM_Size, MEM_SignExtend, MEM_Address, MEM_WriteData,
        output Bus_Ready, Bus_ReadData,
        input  MEM_Stall_Controller, MEM_ReadData, MEM_BusError,
        input  Bus_Address, Bus_WriteData, Bus_ByteEnable, Bus_Read, Bus_Write
    );
endinterface

// File: rtl/mem_access_controller.sv
// Runs MEM-stage loads/stores on a multi-cycle data bus, stalling the pipeline until done.
// Define MEM_ALIGN_CHECK_EN to reject misaligned half/word accesses without a bus cycle.
module mem_access_controller #(
    parameter int unsigned MAX_WAIT = 255
) (
    input logic                    clock,
    input logic                    reset_n,
    mem_access_controller_if.slave bus
);
    localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]     addr_q, wdata_q, rdata_q, rdata_d;
    logic [1:0]      lane_q, size_q;
    logic [3:0]      be_q;
    logic            sext_q;
    logic            rd_q, rd_d, wr_q, wr_d, err_q, err_d;
    logic            latch_en, stall, req, misaligned;
    logic [1:0]      lane;
    logic [3:0]      be_req;
    logic [31:0]     wdata_req, load_val;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    assign req  = bus.MEM_MemRead | bus.MEM_MemWrite;
    assign lane = bus.MEM_Address[1:0];

    always_comb begin
        be_req    = 4'b1111;
        wdata_req = bus.MEM_WriteData;
        case (bus.MEM_Size)
            2'b00: begin
                be_req    = 4'b0001 << lane;
                wdata_req = {4{bus.MEM_WriteData[7:0]}};
            end
            2'b01: begin
                be_req    = 4'b0011 << {lane[1], 1'b0};
                wdata_req = {2{bus.MEM_WriteData[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = ((bus.MEM_Size == 2'b01) && lane[0]) ||
                        (bus.MEM_Size[1] && (lane != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Load lane select and extension, using the attributes latched at request time.
    always_comb begin
        unique case (lane_q)
            2'd0: ld_byte = bus.Bus_ReadData[7:0];
            2'd1: ld_byte = bus.Bus_ReadData[15:8];
            2'd2: ld_byte = bus.Bus_ReadData[23:16];
            2'd3: ld_byte = bus.Bus_ReadData[31:24];
        endcase
        ld_half = lane_q[1] ? bus.Bus_ReadData[31:16] : bus.Bus_ReadData[15:0];
        case (size_q)
            2'b00:   load_val = {{24{sext_q & ld_byte[7]}}, ld_byte};
            2'b01:   load_val = {{16{sext_q & ld_half[15]}}, ld_half};
            default: load_val = bus.Bus_ReadData;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        latch_en   = 1'b0;
        stall      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    stall      = 1'b1;
                    wait_cnt_d = '0;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        latch_en = 1'b1;
                        err_d    = 1'b0;
                        rd_d     = ~bus.MEM_MemWrite;
                        wr_d     = bus.MEM_MemWrite;
                        state_d  = StAccess;
                    end
                end
            end
            StAccess: begin
                stall      = 1'b1;
                wait_cnt_d = wait_cnt_q + CntW'(1);
                if (bus.Bus_Ready) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = StDone;
                    if (rd_q) rdata_d = load_val;
                end else if ((MAX_WAIT != 0) && (wait_cnt_q == CntW'(MAX_WAIT - 1))) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                // The request still visible here belongs to the finished instruction.
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            lane_q     <= '0;
            size_q     <= '0;
            sext_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            if (latch_en) begin
                addr_q  <= {bus.MEM_Address[31:2], 2'b00};
                wdata_q <= wdata_req;
                be_q    <= be_req;
                lane_q  <= lane;
                size_q  <= bus.MEM_Size;
                sext_q  <= bus.MEM_SignExtend;
            end
        end
    end

    // Gated with reset so the stall cannot follow a request held during reset.
    assign bus.MEM_Stall_Controller = stall & reset_n;
    assign bus.MEM_ReadData         = rdata_q;
    assign bus.MEM_BusError         = (state_q == StDone) & err_q;
    assign bus.Bus_Address          = addr_q;
    assign bus.Bus_WriteData        = wdata_q;
    assign bus.Bus_ByteEnable       = be_q;
    assign bus.Bus_Read             = rd_q;
    assign bus.Bus_Write            = wr_q;
endmodule

// File: tb/tb_mem_access_controller.sv
// Scoreboard bench for mem_access_controller: a driver pushes expected responses computed by a
// lane/arithmetic reference model; a negedge monitor pops and compares at each completion.
module tb_mem_access_controller;
    localparam int unsigned MaxWait = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    mem_access_controller_if bus_if ();

    mem_access_controller #(.MAX_WAIT(MaxWait)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          stall_cycles;
        int          strobe_cycles;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] load_value(input logic [31:0] d, input logic [1:0] a,
                                               input logic [1:0] size, input logic sext);
        logic [31:0] v;
        if (size == 2'b00) begin
            v = (d >> (8 * a)) & 32'h0000_00FF;
            if (sext && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = (d >> (16 * a[1])) & 32'h0000_FFFF;
            if (sext && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    task automatic idle_cycle();
        @(posedge clock);
        #1;
        bus_if.MEM_MemRead  = 1'b0;
        bus_if.MEM_MemWrite = 1'b0;
        bus_if.Bus_Ready    = 1'b0;
    endtask

    // Issue one request and play the bus side; expected outcome goes to the scoreboard first.
    task automatic run_txn(input logic rd, input logic wr, input logic [1:0] size,
                           input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] bus_rdata, input int delay);
        exp_t       e;
        logic [1:0] a;
        int         base, n, access_cycles;
        logic       misal, timeout;
        a     = addr[1:0];
        n     = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        base  = (size == 2'b00) ? int'(a) : (size == 2'b01) ? int'(a & 2'b10) : 0;
        e.be  = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= base && i < base + n) e.be[i] = 1'b1;
            e.wdata[8*i +: 8] = wdata[8*(i % n) +: 8];
        end
        e.addr     = {addr[31:2], 2'b00};
        e.is_write = wr;
        misal      = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        misal = ((size == 2'b01) && a[0]) || (size[1] && (a != 2'b00));
`endif
        timeout = (MaxWait != 0) && (delay >= int'(MaxWait));
        if (misal) begin
            e.err = 1'b1; e.stall_cycles = 1; e.strobe_cycles = 0;
        end else if (timeout) begin
            e.err = 1'b1; e.stall_cycles = 1 + MaxWait; e.strobe_cycles = MaxWait;
            model_rdata = '0;
        end else begin
            e.err = 1'b0; e.stall_cycles = delay + 2; e.strobe_cycles = delay + 1;
            if (!wr) model_rdata = load_value(bus_rdata, a, size, sext);
        end
        e.rdata = model_rdata;
        exp_q.push_back(e);

        @(posedge clock);
        #1;
        bus_if.MEM_MemRead    = rd;
        bus_if.MEM_MemWrite   = wr;
        bus_if.MEM_Size       = size;
        bus_if.MEM_SignExtend = sext;
        bus_if.MEM_Address    = addr;
        bus_if.MEM_WriteData  = wdata;
        bus_if.Bus_Ready      = 1'b0;
        if (!misal) begin
            access_cycles = timeout ? int'(MaxWait) : delay + 1;
            for (int c = 0; c < access_cycles; c++) begin
                @(posedge clock);
                #1;
                bus_if.Bus_Ready    = !timeout && (c == delay);
                bus_if.Bus_ReadData = (c == delay) ? bus_rdata : $urandom();
            end
        end
        @(posedge clock);
        #1;
        bus_if.Bus_Ready = 1'b0;
    endtask

    // Monitor: a completion is the cycle where stall falls after being high.
    initial begin
        int          stall_run, rd_run, wr_run;
        logic        prev_stall, cap_valid, unstable;
        logic [31:0] cap_addr, cap_wdata;
        logic [3:0]  cap_be;
        exp_t        e;
        stall_run = 0; rd_run = 0; wr_run = 0;
        prev_stall = 1'b0; cap_valid = 1'b0; unstable = 1'b0;
        cap_addr = '0; cap_wdata = '0; cap_be = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                stall_run = 0; rd_run = 0; wr_run = 0;
                prev_stall = 1'b0; cap_valid = 1'b0; unstable = 1'b0;
            end else begin
                if (bus_if.Bus_Read || bus_if.Bus_Write) begin
                    if (bus_if.Bus_Read) rd_run++;
                    if (bus_if.Bus_Write) wr_run++;
                    if (!cap_valid) begin
                        cap_valid = 1'b1;
                        cap_addr  = bus_if.Bus_Address;
                        cap_be    = bus_if.Bus_ByteEnable;
                        cap_wdata = bus_if.Bus_WriteData;
                    end else if (cap_addr !== bus_if.Bus_Address ||
                                 cap_be !== bus_if.Bus_ByteEnable ||
                                 cap_wdata !== bus_if.Bus_WriteData) begin
                        unstable = 1'b1;
                    end
                end
                if (prev_stall && !bus_if.MEM_Stall_Controller) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion: got a completion, expected none");
                    end else begin
                        e = exp_q.pop_front();
                        check("stall_cycles", stall_run, e.stall_cycles);
                        check("read_strobe_cycles", rd_run, e.is_write ? 0 : e.strobe_cycles);
                        check("write_strobe_cycles", wr_run, e.is_write ? e.strobe_cycles : 0);
                        if (e.strobe_cycles > 0) begin
                            check("bus_address", cap_addr, e.addr);
                            check("byte_enable", {28'd0, cap_be}, {28'd0, e.be});
                            check("bus_stable", {31'd0, unstable}, 32'd0);
                            if (e.is_write) check("bus_write_data", cap_wdata, e.wdata);
                        end
                        check("read_data", bus_if.MEM_ReadData, e.rdata);
                        check("bus_error_done", {31'd0, bus_if.MEM_BusError}, {31'd0, e.err});
                    end
                    stall_run = 0; rd_run = 0; wr_run = 0;
                    cap_valid = 1'b0; unstable = 1'b0;
                end else begin
                    check("bus_error_quiet", {31'd0, bus_if.MEM_BusError}, 32'd0);
                end
                if (bus_if.MEM_Stall_Controller) stall_run++;
                prev_stall = bus_if.MEM_Stall_Controller;
            end
        end
    end

    initial begin
        logic        rd, wr, sext;
        logic [1:0]  size;
        logic [31:0] addr, wd, rb;
        int          dly;
        bus_if.MEM_MemRead    = 1'b0;
        bus_if.MEM_MemWrite   = 1'b0;
        bus_if.MEM_Size       = 2'b00;
        bus_if.MEM_SignExtend = 1'b0;
        bus_if.MEM_Address    = '0;
        bus_if.MEM_WriteData  = '0;
        bus_if.Bus_Ready      = 1'b0;
        bus_if.Bus_ReadData   = '0;

        #2 reset_n = 1'b0;
        #2;
        check("rst_stall", {31'd0, bus_if.MEM_Stall_Controller}, 32'd0);
        check("rst_read_data", bus_if.MEM_ReadData, 32'd0);
        check("rst_bus_error", {31'd0, bus_if.MEM_BusError}, 32'd0);
        check("rst_bus_read", {31'd0, bus_if.Bus_Read}, 32'd0);
        check("rst_bus_write", {31'd0, bus_if.Bus_Write}, 32'd0);
        check("rst_bus_address", bus_if.Bus_Address, 32'd0);
        check("rst_byte_enable", {28'd0, bus_if.Bus_ByteEnable}, 32'd0);
        check("rst_bus_write_data", bus_if.Bus_WriteData, 32'd0);
        #8 reset_n = 1'b1;

        run_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
        run_txn(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 0);
        run_txn(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 1);
        run_txn(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_ABCD, 32'h0, 3);
        idle_cycle();
        run_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 10);
        run_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 32'hCAFE_F00D, 0);
        run_txn(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h0000_005A, 32'h0, 2);
        idle_cycle();

        // Reset in mid-access: strobe and stall must fall without waiting for a clock edge.
        @(posedge clock);
        #1;
        bus_if.MEM_MemRead  = 1'b1;
        bus_if.MEM_MemWrite = 1'b0;
        bus_if.MEM_Size     = 2'b10;
        bus_if.MEM_Address  = 32'h0000_0300;
        @(posedge clock);
        #3;
        check("pre_reset_bus_read", {31'd0, bus_if.Bus_Read}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_reset_bus_read", {31'd0, bus_if.Bus_Read}, 32'd0);
        check("async_reset_stall", {31'd0, bus_if.MEM_Stall_Controller}, 32'd0);
        check("async_reset_read_data", bus_if.MEM_ReadData, 32'd0);
        bus_if.MEM_MemRead = 1'b0;
        model_rdata = '0;
        @(negedge clock);
        #2 reset_n = 1'b1;
        run_txn(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0306, 32'h0, 32'h9876_0000, 1);

        for (int t = 0; t < 200; t++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            size = 2'($urandom_range(0, 3));
            sext = 1'($urandom_range(0, 1));
            addr = $urandom();
            wd   = $urandom();
            rb   = $urandom();
            dly  = wr ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 5));
            run_txn(rd, wr, size, sext, addr, wd, rb, dly);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        idle_cycle();
        repeat (3) @(posedge clock);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
- Responder side of the MEM-stage stall handshake: takes the MEM stage's load/store request and runs it on a multi-cycle data bus.
- Drives MEM_Stall_Controller into Hazard_Detection until the access completes.
- Sits between the EX/MEM pipeline registers and the data-memory bus.
- Returns byte/half/word load data, sign- or zero-extended.

Parameters:
- MAX_WAIT, 255, number of ACCESS cycles without Bus_Ready before the access is aborted; 0 disables the timeout.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- MEM_MemRead  in  1  load request from MEM stage.
- MEM_MemWrite  in  1  store request from MEM stage.
- MEM_Size  in  2  access size: 00 byte, 01 half, 10/11 word.
- MEM_SignExtend  in  1  sign-extend byte/half loads; 0 zero-extends.
- MEM_Address  in  32  byte address (ALU result).
- MEM_WriteData  in  32  store data, right-aligned.
- MEM_Stall_Controller  out  1  access pending; hold the pipeline.
- MEM_ReadData  out  32  formatted load result.
- MEM_BusError  out  1  one-cycle pulse on timeout (or misalignment, see below).
- Bus_Address  out  32  word address, low 2 bits forced to 0.
- Bus_WriteData  out  32  store data replicated to all lanes.
- Bus_ByteEnable  out  4  active lanes.
- Bus_Read  out  1  read strobe.
- Bus_Write  out  1  write strobe.
- Bus_Ready  in  1  bus completion, sampled each cycle.
- Bus_ReadData  in  32  read data, valid with Bus_Ready.

Behaviour:
- Reset (async, reset_n=0): state IDLE, wait counter 0, all outputs 0. Reset in mid-access drops the bus strobes immediately and discards the access.
- States: IDLE, ACCESS, DONE.
- IDLE, request present (MEM_MemRead | MEM_MemWrite):
  - MEM_Stall_Controller=1 combinationally in the same cycle.
  - Latch address, size, sign, data and byte enables.
  - Next state ACCESS.
  - If both read and write are high, treat the request as a write.
- IDLE, no request: stall=0, strobes=0.
- ACCESS:
  - Bus_Read or Bus_Write is registered high, with Address/WriteData/ByteEnable held stable until Bus_Ready is sampled high.
  - Stall=1.
  - Wait counter increments each cycle.
- ACCESS, Bus_Ready=1:
  - Strobes deassert the next cycle.
  - On a read, MEM_ReadData is registered from the formatted Bus_ReadData.
  - Next state DONE.
- ACCESS, timeout (counter reaches MAX_WAIT with Bus_Ready=0, MAX_WAIT≠0):
  - Strobes drop, MEM_ReadData=0.
  - MEM_BusError=1 during DONE.
- DONE:
  - Stall=0 for exactly one cycle so the pipeline advances.
  - The request still visible this cycle belongs to the finished instruction and is ignored.
  - Next state IDLE unconditionally.
- Minimum latency: request in cycle 0, strobe cycle 1, Bus_Ready in cycle 1 gives DONE in cycle 2. Stall is high for cycles 0–1.
- Byte enables (little-endian, a = MEM_Address[1:0]):
  - byte: 4'b0001<<a
  - half: 4'b0011<<{a[1],1'b0}
  - word: 4'b1111
- Bus_WriteData replication: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
- Load formatting: select lane a (byte) or a[1] (half), then extend per MEM_SignExtend to 32 bits.
- MEM_ReadData holds its value until the next completed read; writes do not alter it.
- MEM_BusError is 0 outside DONE.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A half access with a[0]=1, or a word access with a≠0, issues no bus cycle.
  - IDLE→DONE directly, with stall high for that one IDLE cycle.
  - MEM_BusError=1 in DONE; MEM_ReadData unchanged.
- Undefined:
  - Misaligned low bits are ignored: half uses a[1], word forces lane 0.
  - Access proceeds normally, and MEM_BusError is driven only by timeout.

Test Plan:
- Word load, addr 0x100, Bus_Ready in first ACCESS cycle, Bus_ReadData 0xDEADBEEF -> stall high 2 cycles, Bus_ByteEnable 4'b1111, MEM_ReadData 0xDEADBEEF in DONE, stall 0.
- Signed byte load, addr 0x103, data 0x80FFFFFF -> Bus_ByteEnable 4'b1000, MEM_ReadData 0xFFFFFF80; with MEM_SignExtend=0 -> 0x00000080.
- Half store, addr 0x22, data 0x0000ABCD, Bus_Ready after 3 wait cycles -> Bus_Write held 4 cycles, ByteEnable 4'b1100, WriteData 0xABCDABCD, stall high 5 cycles.
- MAX_WAIT=4, Bus_Ready never asserted -> strobes drop after 4 ACCESS cycles, DONE with MEM_BusError=1, MEM_ReadData=0.
- reset_n pulsed low during ACCESS -> Bus_Read and stall fall immediately (async); a fresh load after reset completes normally.
- With MEM_ALIGN_CHECK_EN, word load at 0x101 -> no Bus_Read, stall high 1 cycle, MEM_BusError pulse; without it -> normal access, ByteEnable 4'b1111.
